d_debounce: RTL and testbench

Input-conditioning stage that sits directly upstream of the `d_ff` block and drives its `d` input. It synchronizes a raw asynchronous level (push-button or switch) into the `clk` domain with a two-flop synchronizer, then filters bounce with a counter-qualified state machine. The clean level `q` is presented only after the input has held a new value for a programmable number of consecutive cycles. Optional one-cycle edge strobes are also provided.

---
 rtl/d_debounce_if.sv | 17 +
 rtl/d_debounce.sv | 155 +++++++++++++++
 tb/tb_d_debounce.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/d_debounce_if.sv
// d_debounce_if
//   Groups the debouncer's data-path signals.
//   din  : raw asynchronous level (driven by the source)
//   q    : debounced level
//   rise : one-cycle strobe when q goes 0->1
//   fall : one-cycle strobe when q goes 1->0
//   modport master : the side that supplies din and consumes q/rise/fall
//   modport slave  : the debouncer itself
interface d_debounce_if;
    logic din;
    logic q;
    logic rise;
    logic fall;

    modport master (output din, input q, input rise, input fall);
    modport slave  (input din, output q, output rise, output fall);
endinterface

// File: rtl/d_debounce.sv
// d_debounce
//   Synchronizes a raw button/switch level into clk with two flops, then
//   accepts a new level only after it has held for STABLE_CNT consecutive
//   synchronized cycles. Drives the d input of the downstream d_ff.
//
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous active-low reset
//     dbus  : d_debounce_if.slave (din in; q, rise, fall out)
//
//   Build option:
//     DEBOUNCE_EDGE_EN defined   -> rise/fall strobes are generated
//     DEBOUNCE_EDGE_EN undefined -> rise/fall are tied to 0
//
//   state     | meaning
//   ----------+-------------------------------------------
//   STABLE_LO | q=0, input agrees with q
//   FILT_HI   | q=0, input high, counting toward qualification
//   STABLE_HI | q=1, input agrees with q
//   FILT_LO   | q=1, input low, counting toward qualification
module d_debounce #(
    parameter int STABLE_CNT = 50000,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         reset,
    d_debounce_if.slave  dbus
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        FILT_HI   = 2'b01,
        STABLE_HI = 2'b11,
        FILT_LO   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    // With a one-cycle qualification window the filter states are skipped.
    localparam bit SINGLE = (STABLE_CNT == 1);

    logic             s1, s2;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             q_r, q_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= dbus.din;
            s2 <= s1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= STABLE_LO;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            STABLE_LO: begin
                cnt_nxt = '0;
                if (s2) begin
                    if (SINGLE) begin
                        state_nxt = STABLE_HI;
                    end else begin
                        state_nxt = FILT_HI;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            FILT_HI: begin
                if (!s2) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                cnt_nxt = '0;
                if (!s2) begin
                    if (SINGLE) begin
                        state_nxt = STABLE_LO;
                    end else begin
                        state_nxt = FILT_LO;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            FILT_LO: begin
                if (s2) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: q is high whenever the next state belongs to the high side.
    always_comb begin
        q_nxt = (state_nxt == STABLE_HI) || (state_nxt == FILT_LO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q_r <= 1'b0;
        else        q_r <= q_nxt;
    end

    assign dbus.q = q_r;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_r, fall_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= q_nxt & ~q_r;
            fall_r <= ~q_nxt & q_r;
        end
    end

    assign dbus.rise = rise_r;
    assign dbus.fall = fall_r;
`else
    assign dbus.rise = 1'b0;
    assign dbus.fall = 1'b0;
`endif

endmodule

// File: tb/tb_d_debounce.sv
// tb_d_debounce
//   Randomized bench for d_debounce (STABLE_CNT=4, CNT_W=4, 100 ns clock).
//   A reference model computes the expected q/rise/fall after each rising
//   edge from a run-length rule and queues it; a monitor pops and compares
//   just after every edge. Works with and without DEBOUNCE_EDGE_EN.
module tb_d_debounce;

    localparam int STABLE_CNT = 4;
    localparam int CNT_W      = 4;

    logic clk;
    logic reset;

    d_debounce_if dbus ();

    d_debounce #(
        .STABLE_CNT (STABLE_CNT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dbus  (dbus)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] exp_q[$];

    // Reference model: q flips once the synchronized input (din seen two
    // edges earlier) has disagreed with q for STABLE_CNT consecutive edges.
    logic hist[$];
    logic q_m   = 1'b0;
    int   run_m = 0;

    initial begin
        logic fin, prev, rise_e, fall_e;
        forever begin
            @(posedge clk);
            if (!reset) begin
                hist.delete();
                q_m   = 1'b0;
                run_m = 0;
                exp_q.push_back(3'b000);
            end else begin
                fin = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
                hist.push_back(dbus.din);
                if (hist.size() > 4) void'(hist.pop_front());
                prev = q_m;
                if (fin != q_m) begin
                    run_m++;
                    if (run_m == STABLE_CNT) begin
                        q_m   = ~q_m;
                        run_m = 0;
                    end
                end else begin
                    run_m = 0;
                end
`ifdef DEBOUNCE_EDGE_EN
                rise_e = q_m & ~prev;
                fall_e = ~q_m & prev;
`else
                rise_e = 1'b0;
                fall_e = 1'b0;
`endif
                exp_q.push_back({q_m, rise_e, fall_e});
            end
        end
    end

    // Monitor
    initial begin
        logic [2:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty at %0t: no expected entry, actual q/rise/fall=%b%b%b",
                         $time, dbus.q, dbus.rise, dbus.fall);
            end else begin
                e = exp_q.pop_front();
                a = {dbus.q, dbus.rise, dbus.fall};
                if (a !== e) begin
                    n_err++;
                    $display("FAIL qrf at %0t: actual q/rise/fall=%b expected=%b", $time, a, e);
                end
            end
        end
    end

    task automatic hold(input logic d, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #20;
            dbus.din = d;
        end
    endtask

    // Assert reset mid-cycle and confirm outputs clear before the next edge.
    task automatic pulse_reset(input int n);
        @(posedge clk);
        #20;
        reset = 1'b0;
        #5;
        n_cmp++;
        if ({dbus.q, dbus.rise, dbus.fall} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset at %0t: actual q/rise/fall=%b%b%b expected=000",
                     $time, dbus.q, dbus.rise, dbus.fall);
        end
        for (int i = 1; i < n; i++) @(posedge clk);
        @(posedge clk);
        #20;
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        dbus.din = 1'b1;
        repeat (3) @(posedge clk);
        #20;
        reset = 1'b1;

        // high din after reset must qualify fully
        hold(1'b1, 8);
        // release
        hold(1'b0, 8);
        // clean press
        hold(1'b1, 8);
        hold(1'b0, 8);
        // bounce 1,0,1,0 then held high
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 10);
        // boundary: runs of STABLE_CNT-1 rejected, STABLE_CNT accepted
        hold(1'b0, 3);
        hold(1'b1, 3);
        hold(1'b0, 4);
        hold(1'b1, 8);
        // mid-filter reset while q=1 side is settled, then from low side
        pulse_reset(1);
        hold(1'b0, 6);
        hold(1'b1, 4);
        pulse_reset(2);
        hold(1'b1, 8);

        // randomized runs of 1..7 cycles with occasional resets
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 24) == 0)
                pulse_reset(int'($urandom_range(1, 2)));
            else
                hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
        end

        hold(dbus.din, 10);
        @(posedge clk);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
